mk_fifo: RTL and testbench
==========================

MK_FIFO -- requirements
Module: mk_fifo

Interface
REQ-001 Parameter width, default 1: data bits per entry; width 0 means a token-only FIFO, the data ports are 1 bit wide and ignored, and IN_ENQ_VALID is treated as 1.
REQ-002 Parameter depth, default 2: number of entries; power of two, at least 2.
REQ-003 CLK  input  1  single clock; all state changes on posedge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 IN_ENQ  input  max(width,1)  enqueue data.
REQ-006 IN_ENQ_VALID  input  1  enqueue-data token present.
REQ-007 IN_ENQ_CONSUMED  output  1  enqueue-data token taken this cycle.
REQ-008 IN_EN_ENQ  input  1  enqueue enable (1 = push, 0 = no-op token).
REQ-009 IN_EN_ENQ_VALID  input  1  enqueue-enable token present.
REQ-010 IN_EN_ENQ_CONSUMED  output  1  enqueue-enable token taken this cycle.
REQ-011 IN_EN_DEQ  input  1  dequeue enable (1 = pop, 0 = no-op token).
REQ-012 IN_EN_DEQ_VALID  input  1  dequeue-enable token present.
REQ-013 IN_EN_DEQ_CONSUMED  output  1  dequeue-enable token taken this cycle.
REQ-014 OUT_FIRST  output  max(width,1)  head entry data.
REQ-015 OUT_FIRST_VALID  output  1  head entry present (FIFO not empty).
REQ-016 OUT_FIRST_CONSUMED  input  1  downstream read acknowledge; informational only, no effect on state.
REQ-017 OUT_COUNT  output  log2(depth)+1  current occupancy, 0..depth.

Function
REQ-018 The FIFO shall be a circular buffer of depth entries, with head and tail pointers of log2(depth) bits that wrap modulo depth.
REQ-019 enqOk shall equal data-valid (IN_ENQ_VALID, or 1 when width is 0) AND IN_EN_ENQ_VALID AND (IN_EN_ENQ==0 OR count<depth).
REQ-020 IN_ENQ_CONSUMED and IN_EN_ENQ_CONSUMED shall both equal enqOk, so the data and enable tokens are always taken together.
REQ-021 A push shall occur on a clock edge when enqOk AND IN_EN_ENQ: IN_ENQ is written at tail, and tail advances by 1.
REQ-022 deqOk shall equal IN_EN_DEQ_VALID AND (IN_EN_DEQ==0 OR count>0), and IN_EN_DEQ_CONSUMED shall equal deqOk.
REQ-023 A pop shall occur on a clock edge when deqOk AND IN_EN_DEQ, and head advances by 1.
REQ-024 OUT_FIRST shall equal the entry at head (combinational read), and OUT_FIRST_VALID shall equal (count>0).
REQ-025 Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
REQ-026 No bypass when full: an enable-1 enqueue shall stall until count<depth, even if a pop occurs in the same cycle.
REQ-027 No bypass when empty: an enable-1 dequeue shall stall until count>0, even if a push occurs in the same cycle.
REQ-028 Data latency shall be 1 cycle: an entry pushed at edge N is visible on OUT_FIRST after edge N when the FIFO was empty.
REQ-029 Enable-0 tokens shall be consumed immediately whenever their VALIDs are present, regardless of full or empty, and shall not change state.
REQ-030 Ordering shall be strict FIFO, and entries shall not be lost or duplicated across pointer wrap.
REQ-031 All CONSUMED outputs shall be combinational functions of the current inputs and state, with no combinational path from OUT_FIRST_CONSUMED.

Reset
REQ-032 When RST_N=0, the block shall immediately, without waiting for CLK, clear head, tail and count to 0, giving OUT_FIRST_VALID=0 and OUT_COUNT=0.
REQ-033 Storage contents shall not be reset, and OUT_FIRST is don't-care while OUT_FIRST_VALID=0.
REQ-034 Reset asserted mid-operation shall discard all entries, and no push or pop shall occur on any edge while RST_N=0.
REQ-035 After RST_N deasserts, the first push shall be allowed on the next clock edge.

Verification
REQ-036 Use width=8, depth=4, and push 0x11, 0x22, 0x33 on 3 edges with DEQ VALID=0; then OUT_COUNT=3, OUT_FIRST=0x11 and OUT_FIRST_VALID=1.
REQ-037 Fill to 4 entries and present an enable-1 enqueue with 0x55; then IN_ENQ_CONSUMED=0, count stays 4, and the enqueue is taken on the edge after one pop.
REQ-038 With the FIFO empty, present an enable-1 dequeue and a push of 0xAA in the same cycle; then IN_EN_DEQ_CONSUMED=0 that cycle, count=1 after the edge, and the next cycle's pop returns 0xAA.
REQ-039 At count=2, push and pop simultaneously for 10 cycles with an incrementing pattern; then count stays 2, pointers wrap, and the output sequence is in order.
REQ-040 Drop RST_N mid-cycle with count=3; then OUT_FIRST_VALID=0 and OUT_COUNT=0 before the next edge.
REQ-041 Send an enable-0 enqueue token while full and an enable-0 dequeue token while empty; then both CONSUMED outputs are 1 and there is no state change.

Source files
------------

// File: rtl/mk_fifo.sv
// mk_fifo: circular-buffer FIFO with token-style enqueue/dequeue enables and occupancy count
//   CLK, RST_N (async active-low)
//   IN_ENQ/_VALID/_CONSUMED         enqueue data token
//   IN_EN_ENQ/_VALID/_CONSUMED      enqueue enable token (0 = no-op)
//   IN_EN_DEQ/_VALID/_CONSUMED      dequeue enable token (0 = no-op)
//   OUT_FIRST/_VALID/_CONSUMED      head entry (CONSUMED is informational only)
//   OUT_COUNT                       occupancy 0..depth
module mk_fifo #(
  parameter int width = 1,
  parameter int depth = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic [((width == 0) ? 1 : width)-1:0]  IN_ENQ,
  input  logic                                   IN_ENQ_VALID,
  output logic                                   IN_ENQ_CONSUMED,
  input  logic                                   IN_EN_ENQ,
  input  logic                                   IN_EN_ENQ_VALID,
  output logic                                   IN_EN_ENQ_CONSUMED,
  input  logic                                   IN_EN_DEQ,
  input  logic                                   IN_EN_DEQ_VALID,
  output logic                                   IN_EN_DEQ_CONSUMED,
  output logic [((width == 0) ? 1 : width)-1:0]  OUT_FIRST,
  output logic                                   OUT_FIRST_VALID,
  input  logic                                   OUT_FIRST_CONSUMED,
  output logic [$clog2(depth):0]                 OUT_COUNT
);
  localparam int DW = (width == 0) ? 1 : width;
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem_q [depth];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic data_vld, full, empty, enq_ok, deq_ok, push, pop;
  logic unused_first_consumed;
  assign unused_first_consumed = OUT_FIRST_CONSUMED;
  // full/empty use the pre-edge count only, so a same-cycle pop cannot make
  // room for a push and a same-cycle push cannot feed a pop
  always_comb begin
    data_vld = (width == 0) ? 1'b1 : IN_ENQ_VALID;
    full = count_q == CW'(depth);
    empty = count_q == '0;
    enq_ok = data_vld & IN_EN_ENQ_VALID & (~IN_EN_ENQ | ~full);
    deq_ok = IN_EN_DEQ_VALID & (~IN_EN_DEQ | ~empty);
    push = enq_ok & IN_EN_ENQ;
    pop = deq_ok & IN_EN_DEQ;
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push && RST_N) mem_q[tail_q] <= IN_ENQ;
  end
  assign IN_ENQ_CONSUMED = enq_ok;
  assign IN_EN_ENQ_CONSUMED = enq_ok;
  assign IN_EN_DEQ_CONSUMED = deq_ok;
  assign OUT_FIRST = mem_q[head_q];
  assign OUT_FIRST_VALID = ~empty;
  assign OUT_COUNT = count_q;
endmodule

// File: tb/tb_mk_fifo.sv
// tb_mk_fifo: randomized and directed checks of mk_fifo against a queue model
module tb_mk_fifo;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [7:0] IN_ENQ = '0;
  logic IN_ENQ_VALID = 1'b0;
  logic IN_ENQ_CONSUMED;
  logic IN_EN_ENQ = 1'b0;
  logic IN_EN_ENQ_VALID = 1'b0;
  logic IN_EN_ENQ_CONSUMED;
  logic IN_EN_DEQ = 1'b0;
  logic IN_EN_DEQ_VALID = 1'b0;
  logic IN_EN_DEQ_CONSUMED;
  logic [7:0] OUT_FIRST;
  logic OUT_FIRST_VALID;
  logic OUT_FIRST_CONSUMED = 1'b0;
  logic [2:0] OUT_COUNT;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  mk_fifo #(.width(8), .depth(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_ENQ(IN_ENQ), .IN_ENQ_VALID(IN_ENQ_VALID), .IN_ENQ_CONSUMED(IN_ENQ_CONSUMED),
    .IN_EN_ENQ(IN_EN_ENQ), .IN_EN_ENQ_VALID(IN_EN_ENQ_VALID), .IN_EN_ENQ_CONSUMED(IN_EN_ENQ_CONSUMED),
    .IN_EN_DEQ(IN_EN_DEQ), .IN_EN_DEQ_VALID(IN_EN_DEQ_VALID), .IN_EN_DEQ_CONSUMED(IN_EN_DEQ_CONSUMED),
    .OUT_FIRST(OUT_FIRST), .OUT_FIRST_VALID(OUT_FIRST_VALID), .OUT_FIRST_CONSUMED(OUT_FIRST_CONSUMED),
    .OUT_COUNT(OUT_COUNT)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic ev, input logic [7:0] d, input logic een, input logic eev,
                       input logic den, input logic dev);
    IN_ENQ_VALID = ev;
    IN_ENQ = d;
    IN_EN_ENQ = een;
    IN_EN_ENQ_VALID = eev;
    IN_EN_DEQ = den;
    IN_EN_DEQ_VALID = dev;
    OUT_FIRST_CONSUMED = 1'($urandom);
  endtask
  task automatic step(input string tag);
    bit ok_e, ok_d, push, pop;
    #3;
    ok_e = IN_ENQ_VALID && IN_EN_ENQ_VALID && (!IN_EN_ENQ || q.size() < 4);
    ok_d = IN_EN_DEQ_VALID && (!IN_EN_DEQ || q.size() > 0);
    push = ok_e && IN_EN_ENQ;
    pop = ok_d && IN_EN_DEQ;
    check({tag, "_count"}, 32'(OUT_COUNT), q.size());
    check({tag, "_first_valid"}, 32'(OUT_FIRST_VALID), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, "_first"}, 32'(OUT_FIRST), 32'(q[0]));
    check({tag, "_enq_cons"}, 32'(IN_ENQ_CONSUMED), 32'(ok_e));
    check({tag, "_en_enq_cons"}, 32'(IN_EN_ENQ_CONSUMED), 32'(ok_e));
    check({tag, "_en_deq_cons"}, 32'(IN_EN_DEQ_CONSUMED), 32'(ok_d));
    @(posedge CLK);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(IN_ENQ);
    #1;
  endtask
  initial begin
    #1;
    check("reset_count", 32'(OUT_COUNT), 0);
    check("reset_valid", 32'(OUT_FIRST_VALID), 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    // three pushes, no dequeue tokens
    drive(1, 8'h11, 1, 1, 0, 0); step("push1");
    drive(1, 8'h22, 1, 1, 0, 0); step("push2");
    drive(1, 8'h33, 1, 1, 0, 0); step("push3");
    drive(0, 8'h00, 0, 0, 0, 0); step("after3");
    check("r036_count", 32'(OUT_COUNT), 3);
    check("r036_first", 32'(OUT_FIRST), 32'h11);
    // fill then stall an enable-1 enqueue until one pop
    drive(1, 8'h44, 1, 1, 0, 0); step("fill4");
    drive(1, 8'h55, 1, 1, 0, 0); step("full_stall");
    check("r037_count", 32'(OUT_COUNT), 4);
    drive(1, 8'h55, 1, 1, 1, 1); step("full_pop");
    drive(1, 8'h55, 1, 1, 0, 0); step("full_take");
    // enable-0 enqueue token while full
    drive(1, 8'h99, 0, 1, 0, 0); step("full_noop");
    check("r041_full_count", 32'(OUT_COUNT), 4);
    // drain
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 0, 0, 1, 1); step("drain");
    end
    // enable-0 dequeue token while empty
    drive(0, 8'h00, 0, 0, 0, 1); step("empty_noop");
    check("r041_empty_count", 32'(OUT_COUNT), 0);
    // dequeue on empty stalls even with same-cycle push
    drive(1, 8'hAA, 1, 1, 1, 1); step("empty_stall");
    drive(0, 8'h00, 0, 0, 1, 1); step("pop_aa");
    // steady state at count 2 with pointer wrap
    drive(1, 8'h00, 1, 1, 0, 0); step("pre_a");
    drive(1, 8'h01, 1, 1, 0, 0); step("pre_b");
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h02 + i), 1, 1, 1, 1); step("steady");
    end
    check("r039_count", 32'(OUT_COUNT), 2);
    check("r039_first", 32'(OUT_FIRST), 32'h0A);
    // bring to 3 then reset mid-cycle
    drive(1, 8'h77, 1, 1, 0, 0); step("to3");
    drive(1, 8'h66, 1, 1, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    check("r040_count", 32'(OUT_COUNT), 0);
    check("r040_valid", 32'(OUT_FIRST_VALID), 0);
    q.delete();
    @(posedge CLK);
    #1;
    check("rst_hold_count", 32'(OUT_COUNT), 0);
    #2 RST_N = 1'b1;
    drive(1, 8'h5A, 1, 1, 0, 0); step("post_rst_push");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 4) != 0));
      step("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
